mem_arbiter: RTL

Arbitrates a single-ported instruction/data memory between the fetch stage and the data (load/store) stage of the pipeline. Each requester holds a request until it gets a one-cycle completion pulse. The arbiter drives the shared memory port with registered signals and raises per-requester stall lines. The fetch stall feeds the fetch stage's `hazard` input, which holds the PC while an instruction read is pending.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter between the fetch and data stages.
// One transaction in flight at a time; memory-side signals are registered,
// completion pulses and stalls are combinational from mem_ack.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                ack_err,
  output logic [31:0]         stall_cycles
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t state, state_nxt;
  logic   last_d;              // 1 when the data stage won the most recent grant
  logic   grant_if, grant_d;

  // Next-state, grant selection and completion pulses
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    case (state)
      IDLE: begin
        // Data wins a tie unless it won last time, so both sides alternate
        if (d_req && !(if_req && last_d)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF: if (mem_ack) begin
        if_valid  = 1'b1;
        state_nxt = IDLE;
      end
      BUSY_D: if (mem_ack) begin
        d_valid   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign if_stall = if_req && !if_valid;
  assign d_stall  = d_req && !d_valid;

  // State and round-robin history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_d)       last_d <= 1'b1;
      else if (grant_if) last_d <= 1'b0;
    end
  end

  // Memory port registers: loaded on grant, held while busy, dropped on ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (grant_d) begin
      mem_en    <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_be    <= d_be;
    end else if (grant_if) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_be    <= '1;
    end else if (state != IDLE && mem_ack) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Sticky spurious-ack flag and saturating fetch-stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (state == IDLE && mem_ack) ack_err <= 1'b1;
      if (if_stall && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
